// File: rtl/sd_spi_responder.sv
// sd_spi_responder: SPI-mode SD card responder (card side of the host link).
// Receives 48-bit command frames on sd_mosi and answers R1/R7 on sd_miso.
// Build option: define SD_RESP_CRC_CHECK_EN to check the CRC7 of each frame;
// without it the CRC field is ignored and no CRC logic exists.
//
// state  | meaning
// HUNT   | waiting for a start bit (0) on sd_mosi while sd_cs_n is low
// RX     | shifting in the remaining 47 frame bits, framing checked on the last
// DECODE | one cycle: cmd_valid high, command executed, response built
// NCR    | sd_miso held high until the response starts
// TX     | response bytes shifted out MSB-first, back-to-back

module sd_spi_responder #(
  parameter int NCR_BYTES  = 1,
  parameter int INIT_POLLS = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sd_cs_n,
  input  logic        sd_mosi,
  output logic        sd_miso,
  output logic        cmd_valid,
  output logic [5:0]  cmd_index,
  output logic [31:0] cmd_arg,
  output logic        busy
);

  typedef enum logic [2:0] {HUNT, RX, DECODE, NCR, TX} fsmState;

  localparam int            PW         = $clog2(INIT_POLLS + 2);
  localparam logic [PW-1:0] POLL_LIMIT = PW'(INIT_POLLS);
  localparam logic [PW-1:0] POLL_MAX   = PW'(INIT_POLLS + 1);
  // The DECODE cycle is the first all-ones bit time, so NCR itself runs one short.
  localparam logic [5:0]    NCR_LOAD   = 6'(NCR_BYTES * 8 - 2);

  fsmState        state, stateNext;
  logic [46:0]    rxShift;      // frame bit k (k>=1) sits at rxShift[k-1] on the last RX cycle
  logic [5:0]     rxLeft;
  logic [5:0]     ncrLeft;
  logic [39:0]    txShift;
  logic [5:0]     txLeft;
  logic           inIdle;
  logic           appCmd;
  logic [PW-1:0]  polls;
  logic [PW-1:0]  pollsInc;
  logic           frameOk;
  logic [7:0]     idleByte;

  logic           inIdleNext;
  logic           appCmdNext;
  logic [PW-1:0]  pollsNext;
  logic [39:0]    respNext;
  logic [5:0]     respLast;

`ifdef SD_RESP_CRC_CHECK_EN
  logic crcOk;

  function automatic logic [6:0] crc7(input logic [39:0] d);
    logic [6:0] c;
    logic       fb;
    c = '0;
    for (int i = 39; i >= 0; i--) begin
      fb = d[i] ^ c[6];
      c  = {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    end
    return c;
  endfunction
`endif

  assign frameOk   = ~rxShift[46] & rxShift[45] & sd_mosi;
  assign idleByte  = {7'd0, inIdle};
  assign pollsInc  = (polls == POLL_MAX) ? POLL_MAX : polls + 1'b1;
  assign busy      = (state != HUNT);
  assign cmd_valid = (state == DECODE);
  assign sd_miso   = (state == TX) ? txShift[39] : 1'b1;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= HUNT;
    else       state <= stateNext;
  end

  // Next-state logic; chip select high always forces HUNT.
  always_comb begin
    stateNext = state;
    case (state)
      HUNT:    if (!sd_mosi) stateNext = RX;
      RX:      if (rxLeft == 6'd0) stateNext = frameOk ? DECODE : HUNT;
      DECODE:  stateNext = NCR;
      NCR:     if (ncrLeft == 6'd0) stateNext = TX;
      TX:      if (txLeft == 6'd0) stateNext = HUNT;
      default: stateNext = HUNT;
    endcase
    if (sd_cs_n) stateNext = HUNT;
  end

  // Command execution: card-state updates and response image for the decoded frame.
  always_comb begin
    inIdleNext = inIdle;
    appCmdNext = 1'b0;
    pollsNext  = polls;
    respNext   = {8'h04 | idleByte, 32'd0};
    respLast   = 6'd7;
    case (cmd_index)
      6'd0: begin
        inIdleNext     = 1'b1;
        pollsNext      = '0;
        respNext[39:32] = 8'h01;
      end
      6'd8: begin
        respNext = {idleByte, 8'h00, 8'h00, 8'h01, cmd_arg[7:0]};
        respLast = 6'd39;
      end
      6'd55: begin
        appCmdNext      = 1'b1;
        respNext[39:32] = idleByte;
      end
      6'd41: begin
        if (appCmd) begin
          pollsNext = pollsInc;
          if (inIdle && (pollsInc <= POLL_LIMIT)) begin
            respNext[39:32] = 8'h01;
          end else begin
            inIdleNext      = 1'b0;
            respNext[39:32] = 8'h00;
          end
        end
      end
      default: ;
    endcase
`ifdef SD_RESP_CRC_CHECK_EN
    if (!crcOk) begin
      inIdleNext = inIdle;
      appCmdNext = appCmd;
      pollsNext  = polls;
      respNext   = {8'h08 | idleByte, 32'd0};
      respLast   = 6'd7;
    end
`endif
  end

  // Datapath: frame shifter, decoded fields, card state, Ncr and TX down-counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      rxShift   <= '0;
      rxLeft    <= 6'd46;
      ncrLeft   <= '0;
      txShift   <= {40{1'b1}};
      txLeft    <= '0;
      inIdle    <= 1'b1;
      appCmd    <= 1'b0;
      polls     <= '0;
      cmd_index <= '0;
      cmd_arg   <= '0;
`ifdef SD_RESP_CRC_CHECK_EN
      crcOk     <= 1'b1;
`endif
    end else begin
      case (state)
        HUNT: begin
          rxShift <= '0;
          rxLeft  <= 6'd46;
        end
        RX: begin
          rxShift <= {rxShift[45:0], sd_mosi};
          rxLeft  <= rxLeft - 1'b1;
          if (stateNext == DECODE) begin
            cmd_index <= rxShift[44:39];
            cmd_arg   <= rxShift[38:7];
`ifdef SD_RESP_CRC_CHECK_EN
            crcOk     <= (crc7(rxShift[46:7]) == rxShift[6:0]);
`endif
          end
        end
        DECODE: begin
          inIdle  <= inIdleNext;
          appCmd  <= appCmdNext;
          polls   <= pollsNext;
          txShift <= respNext;
          txLeft  <= respLast;
          ncrLeft <= NCR_LOAD;
        end
        NCR: ncrLeft <= ncrLeft - 1'b1;
        TX: begin
          txShift <= {txShift[38:0], 1'b1};
          txLeft  <= txLeft - 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sd_spi_responder.sv
// Bench for sd_spi_responder: directed scenarios plus randomized command stream,
// checked against a card-level reference model (idle flag, app flag, poll count).
module tb_sd_spi_responder;

  localparam int NCR_BYTES  = 1;
  localparam int INIT_POLLS = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        sd_cs_n;
  logic        sd_mosi;
  logic        sd_miso;
  logic        cmd_valid;
  logic [5:0]  cmd_index;
  logic [31:0] cmd_arg;
  logic        busy;

  int errCount = 0;
  int chkCount = 0;

  bit mIdle;
  bit mApp;
  int mPolls;

  sd_spi_responder #(.NCR_BYTES(NCR_BYTES), .INIT_POLLS(INIT_POLLS)) dut (
    .clk       (clk),
    .reset     (reset),
    .sd_cs_n   (sd_cs_n),
    .sd_mosi   (sd_mosi),
    .sd_miso   (sd_miso),
    .cmd_valid (cmd_valid),
    .cmd_index (cmd_index),
    .cmd_arg   (cmd_arg),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    chkCount++;
    if (got !== exp) begin
      errCount++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // CRC7 by polynomial long division of the 40 message bits times x^7.
  function automatic logic [6:0] refCrc7(input logic [39:0] d);
    logic [46:0] r;
    r = {d, 7'd0};
    for (int i = 46; i >= 7; i--)
      if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'h89;
    return r[6:0];
  endfunction

  task automatic modelReset();
    mIdle  = 1'b1;
    mApp   = 1'b0;
    mPolls = 0;
  endtask

  task automatic modelCmd(input logic [5:0] idx, input logic [31:0] arg, input bit crcGood,
                          output logic [39:0] resp, output int nBytes);
    logic [7:0] r1;
    nBytes = 1;
    resp   = '0;
    r1     = 8'h04 | {7'd0, mIdle};
    if (!crcGood) begin
      r1 = 8'h08 | {7'd0, mIdle};
    end else if (idx == 6'd0) begin
      mIdle = 1'b1; mApp = 1'b0; mPolls = 0; r1 = 8'h01;
    end else if (idx == 6'd8) begin
      r1 = {7'd0, mIdle}; mApp = 1'b0; nBytes = 5;
      resp = {r1, 8'h00, 8'h00, 8'h01, arg[7:0]};
    end else if (idx == 6'd55) begin
      mApp = 1'b1; r1 = {7'd0, mIdle};
    end else if (idx == 6'd41 && mApp) begin
      mApp = 1'b0;
      if (mPolls < INIT_POLLS + 1) mPolls++;
      if (mIdle && mPolls <= INIT_POLLS) r1 = 8'h01;
      else begin mIdle = 1'b0; r1 = 8'h00; end
    end else begin
      mApp = 1'b0;
    end
    if (nBytes == 1) resp = {r1, 32'd0};
  endtask

  function automatic logic [47:0] mkFrame(input logic [5:0] idx, input logic [31:0] arg, input bit badCrc);
    logic [6:0] crc;
    crc = refCrc7({2'b01, idx, arg});
    if (badCrc) crc = crc ^ 7'h01;
    return {2'b01, idx, arg, crc, 1'b1};
  endfunction

  task automatic sendBits(input logic [47:0] f, input int nBits);
    for (int i = 47; i > 47 - nBits; i--) begin
      @(negedge clk);
      sd_mosi = f[i];
    end
  endtask

  task automatic doCmd(input logic [5:0] idx, input logic [31:0] arg, input bit badCrc);
    logic [39:0] expResp, gotResp;
    int          n, ones;
    bit          crcGood, busyAll;
    logic        validLate;
    crcGood = 1'b1;
`ifdef SD_RESP_CRC_CHECK_EN
    crcGood = !badCrc;
`endif
    modelCmd(idx, arg, crcGood, expResp, n);
    sendBits(mkFrame(idx, arg, badCrc), 48);
    @(negedge clk);
    sd_mosi = 1'b1;
    check("cmd_valid", 64'(cmd_valid), 64'd1);
    check("cmd_index", 64'(cmd_index), 64'(idx));
    check("cmd_arg", 64'(cmd_arg), 64'(arg));
    ones = int'(sd_miso);
    validLate = 1'b0;
    for (int i = 1; i < NCR_BYTES * 8; i++) begin
      @(negedge clk);
      ones += int'(sd_miso);
      validLate |= cmd_valid;
    end
    check("ncr_ones", 64'(ones), 64'(NCR_BYTES * 8));
    check("valid_pulse", 64'(validLate), 64'd0);
    gotResp = '0;
    busyAll = 1'b1;
    for (int i = 0; i < n * 8; i++) begin
      @(negedge clk);
      gotResp = {gotResp[38:0], sd_miso};
      busyAll &= busy;
    end
    gotResp = gotResp << (40 - n * 8);
    check($sformatf("resp_cmd%0d", idx), 64'(gotResp), 64'(expResp));
    check("busy_tx", 64'(busyAll), 64'd1);
    @(negedge clk);
    check("busy_end", 64'(busy), 64'd0);
    check("miso_idle", 64'(sd_miso), 64'd1);
  endtask

  initial begin
    logic [47:0] f;
    logic [39:0] er;
    int          en;
    bit          sawValid, sawZero;
    int          r;
    logic [5:0]  idx;

    reset   = 1'b1;
    sd_cs_n = 1'b1;
    sd_mosi = 1'b1;
    modelReset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("rst_miso", 64'(sd_miso), 64'd1);
    check("rst_valid", 64'(cmd_valid), 64'd0);
    check("rst_index", 64'(cmd_index), 64'd0);
    check("rst_arg", 64'(cmd_arg), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    sd_cs_n = 1'b0;
    repeat (2) @(negedge clk);

    doCmd(6'd0, 32'h0, 1'b0);
    doCmd(6'd8, 32'h0000_01AA, 1'b0);
    for (int k = 0; k < 3; k++) begin
      doCmd(6'd55, 32'h0, 1'b0);
      doCmd(6'd41, 32'h4000_0000, 1'b0);
    end
    doCmd(6'd55, 32'h0, 1'b0);
    doCmd(6'd0, 32'h0, 1'b0);
    doCmd(6'd17, 32'h0, 1'b0);

    // Framing error: end bit 0 gives no response and no cmd_valid.
    f = mkFrame(6'd17, 32'h0, 1'b0);
    f[0] = 1'b0;
    sendBits(f, 48);
    sawValid = 1'b0;
    sawZero  = 1'b0;
    @(negedge clk);
    sd_mosi = 1'b1;
    check("frm_busy", 64'(busy), 64'd0);
    for (int i = 0; i < 60; i++) begin
      sawValid |= cmd_valid;
      sawZero  |= ~sd_miso;
      @(negedge clk);
    end
    check("frm_valid", 64'(sawValid), 64'd0);
    check("frm_miso", 64'(sawZero), 64'd0);

    // Chip select raised after 20 frame bits.
    sendBits(mkFrame(6'd8, 32'h1234_5678, 1'b0), 20);
    @(negedge clk);
    sd_cs_n = 1'b1;
    sd_mosi = 1'b1;
    @(negedge clk);
    check("csrx_busy", 64'(busy), 64'd0);
    sd_cs_n = 1'b0;
    @(negedge clk);
    doCmd(6'd0, 32'h0, 1'b0);

    // Chip select raised during the tenth response bit of an R7.
    modelCmd(6'd8, 32'h0000_01AA, 1'b1, er, en);
    sendBits(mkFrame(6'd8, 32'h0000_01AA, 1'b0), 48);
    repeat (NCR_BYTES * 8 + 10) @(negedge clk);
    sd_mosi = 1'b1;
    sd_cs_n = 1'b1;
    @(negedge clk);
    check("cstx_miso", 64'(sd_miso), 64'd1);
    check("cstx_busy", 64'(busy), 64'd0);
    sd_cs_n = 1'b0;
    @(negedge clk);

    // CMD0 with CRC byte 0x97.
    doCmd(6'd0, 32'h0, 1'b1);

    // Reset while the response is pending.
    sendBits(mkFrame(6'd55, 32'h0, 1'b0), 48);
    repeat (3) @(negedge clk);
    sd_mosi = 1'b1;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    modelReset();
    check("mrst_busy", 64'(busy), 64'd0);
    check("mrst_index", 64'(cmd_index), 64'd0);
    check("mrst_miso", 64'(sd_miso), 64'd1);
    @(negedge clk);
    doCmd(6'd41, 32'h0, 1'b0);

    // Randomized command stream.
    for (int k = 0; k < 50; k++) begin
      r = int'($urandom_range(0, 9));
      case (r)
        0:       idx = 6'd0;
        1, 2:    idx = 6'd8;
        3, 4, 5: idx = 6'd55;
        6, 7:    idx = 6'd41;
        8:       idx = 6'd17;
        default: idx = 6'($urandom_range(0, 63));
      endcase
      doCmd(idx, $urandom, ($urandom_range(0, 7) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errCount, chkCount);
    $finish;
  end

endmodule
